lc3_bus_arbiter: RTL and testbench
==================================

Name: lc3_bus_arbiter

Overview:
- Owns the four bus gates: GateMARMUX, GateALU, GateMDR and GatePC.
- Requesters raise a request line. The arbiter grants exactly one gate at a time, or none.
- It inserts a one-cycle turnaround between owners so two drivers never overlap.
- It bounds how long any owner may hold the bus.
- Sits between the control/sequencing logic and the bus driver. Its o_Gnt bits drive the gate inputs directly.

Parameters:
- N_REQ, 4, number of requesters/gates. Index 0 = MARMUX, 1 = ALU, 2 = MDR, 3 = PC.
- MAX_HOLD, 8, maximum consecutive grant cycles per owner. 0 = unlimited.

Ports:
- i_Clk  in  1  system clock, rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Req  in  N_REQ  per-requester bus request, level, held while bus needed
- o_Gnt  out  N_REQ  registered one-hot gate enables (bit i = gate i); all-zero when bus idle
- o_Owner  out  $clog2(N_REQ)  index of current owner; valid only while o_Busy=1
- o_Busy  out  1  1 while any o_Gnt bit set
- o_Timeout  out  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD

Behaviour:
- Clocking and reset:
  - One clock, i_Clk. Reset i_Rst_n is asynchronous, active-low.
  - On reset assertion, immediately: o_Gnt=0, o_Owner=0, o_Busy=0, o_Timeout=0, state=IDLE, rr pointer=0, hold count=0.
  - Reset mid-grant drops the gate the same instant, with no clock edge needed.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If i_Req≠0 at an edge, the winner is granted at that edge: o_Gnt one-hot, next state GRANT.
  - Latency from request to gate = 1 cycle.
  - If i_Req=0, stay in IDLE.
- GRANT:
  - Hold count starts at 1 on the grant edge and increments each cycle.
  - Stay while i_Req[owner]=1 and (MAX_HOLD=0 or count<MAX_HOLD).
  - If i_Req[owner] is sampled 0: o_Gnt←0 at that edge, next state TURN.
  - If count==MAX_HOLD with the request still high: o_Gnt←0 and o_Timeout←1 for one cycle, next state TURN.
  - Requests from other requesters never preempt an owner.
- TURN:
  - Exactly one cycle with o_Gnt=0 (the dead cycle).
  - Arbitration is evaluated during TURN. If i_Req≠0, the winner is granted at the next edge (GRANT); otherwise go to IDLE.
  - Release-to-next-grant gap = 1 dead cycle.
- Winner selection: default is fixed priority, lowest index wins (MARMUX > ALU > MDR > PC).
- Timeout exclusion:
  - A requester released by timeout is excluded from the arbitration performed in the following TURN.
  - If it is the only requester, the bus stays idle for that cycle. It is re-granted in the cycle after, via IDLE.
- Invariants:
  - o_Gnt is always zero or one-hot.
  - o_Busy = |o_Gnt.
  - o_Owner holds the last value while idle.
- Hold count: width $clog2(MAX_HOLD+1); saturates; never wraps.

Optional Feature:
- Macro: LC3_BUS_RR_EN.
- Defined: round-robin arbitration.
  - The rr pointer is set to (owner+1) mod N_REQ on each grant.
  - The search starts at the pointer and wraps past N_REQ-1 to 0.
  - Reset pointer = 0.
  - The timeout exclusion still applies.
- Undefined: fixed priority as above. The rr pointer register is not built.

Decomposition:
- Package lc3_bus_pkg:
  - State enum (IDLE, GRANT, TURN).
  - Gate index constants GATE_MARMUX=0, GATE_ALU=1, GATE_MDR=2, GATE_PC=3.
  - N_GATES=4.
- Sub-module lc3_bus_picker: combinational pick of a one-hot winner and index, from the request vector, exclusion mask and start pointer. It is reused by both arbitration modes.

Test Plan:
- Reset then i_Req=4'b0100 → o_Gnt=4'b0100, o_Owner=2, o_Busy=1 one edge later. Drop the request → o_Gnt=0 next edge, then one TURN cycle, then IDLE.
- i_Req=4'b1010 from IDLE → fixed mode grants ALU (0010). After ALU drops, one dead cycle, then PC (1000).
- MAX_HOLD=8, i_Req=4'b0001 held → o_Gnt=0001 for exactly 8 cycles. Then o_Timeout pulses 1 cycle with o_Gnt=0, TURN, IDLE, and MARMUX is re-granted.
- MAX_HOLD=8, i_Req=4'b0011 held → after 8 MARMUX cycles and the timeout, ALU is granted after the TURN cycle; an ALU timeout is followed by a MARMUX grant.
- LC3_BUS_RR_EN defined, i_Req=4'b1111 held, with each owner dropping its request after 2 cycles then re-requesting → grant order 0,1,2,3,0; dead cycle between each.
- Assert i_Rst_n=0 mid-grant (between edges) → o_Gnt, o_Busy and o_Timeout go 0 immediately. After release with i_Req=4'b1000 → PC granted one edge later.

Source files
------------

// File: rtl/lc3_bus_pkg.sv
// lc3_bus_pkg: shared state encoding and gate indices for the LC-3 bus arbiter
package lc3_bus_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, TURN} bus_state_e;
   localparam int N_GATES     = 4;
   localparam int GATE_MARMUX = 0;
   localparam int GATE_ALU    = 1;
   localparam int GATE_MDR    = 2;
   localparam int GATE_PC     = 3;
endpackage

// File: rtl/lc3_bus_arbiter_if.sv
// lc3_bus_arbiter_if: request/grant bundle between bus requesters and the gate arbiter
interface lc3_bus_arbiter_if #(parameter int N_REQ = lc3_bus_pkg::N_GATES);
   logic [N_REQ-1:0]         req;
   logic [N_REQ-1:0]         gnt;
   logic [$clog2(N_REQ)-1:0] owner;
   logic                     busy;
   logic                     timeout;
   modport master (input req, output gnt, owner, busy, timeout);
   modport slave (output req, input gnt, owner, busy, timeout);
endinterface

// File: rtl/lc3_bus_picker.sv
// lc3_bus_picker: first eligible requester at or after start, wrapping; shared by fixed and round-robin modes
module lc3_bus_picker import lc3_bus_pkg::*; #(
   parameter int N_REQ = N_GATES
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         excl,
   input  logic [$clog2(N_REQ)-1:0] start,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     valid
);
   localparam int IW = $clog2(N_REQ);
   localparam logic [IW:0] NR = (IW+1)'(N_REQ);
   logic [N_REQ-1:0] rot;
   logic [IW:0]      sum;
   // rotate so bit 0 of rot is the requester at start
   assign rot = N_REQ'({req & ~excl, req & ~excl} >> start);
   always_comb begin
      valid = 1'b0;
      sum = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) begin
            valid = 1'b1;
            sum = {1'b0, start} + (IW+1)'(i);
         end
   end
   assign idx = sum >= NR ? IW'(sum - NR) : sum[IW-1:0];
   assign gnt = valid ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/lc3_bus_arbiter.sv
// lc3_bus_arbiter: one-hot gate arbiter with turnaround cycle and hold limit
// Define LC3_BUS_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module lc3_bus_arbiter import lc3_bus_pkg::*; #(
   parameter int N_REQ    = N_GATES,
   parameter int MAX_HOLD = 8
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   lc3_bus_arbiter_if.master bus
);
   localparam int IW = $clog2(N_REQ);
   localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
   bus_state_e       state;
   logic [HW-1:0]    hold;
   logic [N_REQ-1:0] excl, pk_gnt;
   logic [IW-1:0]    start, pk_idx;
   logic             pk_valid, own_req, hit_max;
   assign own_req = bus.req[bus.owner];
   assign hit_max = MAX_HOLD != 0 && hold == HW'(MAX_HOLD);
   // timeout is high only during the TURN after a forced release, so it doubles as the exclusion flag
   assign excl = bus.timeout ? N_REQ'(1) << bus.owner : '0;
`ifdef LC3_BUS_RR_EN
   logic [IW-1:0] rr_ptr;
   assign start = rr_ptr;
`else
   assign start = '0;
`endif
   lc3_bus_picker #(.N_REQ(N_REQ)) u_picker (
      .req   (bus.req),
      .excl  (excl),
      .start (start),
      .gnt   (pk_gnt),
      .idx   (pk_idx),
      .valid (pk_valid)
   );
   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) begin
         state       <= IDLE;
         hold        <= '0;
         bus.gnt     <= '0;
         bus.owner   <= '0;
         bus.busy    <= 1'b0;
         bus.timeout <= 1'b0;
`ifdef LC3_BUS_RR_EN
         rr_ptr      <= '0;
`endif
      end else begin
         bus.timeout <= 1'b0;
         if (state == GRANT) begin
            if (!own_req || hit_max) begin
               state       <= TURN;
               hold        <= '0;
               bus.gnt     <= '0;
               bus.busy    <= 1'b0;
               bus.timeout <= own_req;
            end else if (hold != '1)
               hold <= hold + HW'(1);
         end else if (pk_valid) begin
            state     <= GRANT;
            hold      <= HW'(1);
            bus.gnt   <= pk_gnt;
            bus.owner <= pk_idx;
            bus.busy  <= 1'b1;
`ifdef LC3_BUS_RR_EN
            rr_ptr    <= pk_idx == IW'(N_REQ - 1) ? '0 : pk_idx + IW'(1);
`endif
         end else
            state <= IDLE;
      end
endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// tb_lc3_bus_arbiter: directed vector table plus async-reset and round-robin sequences
module tb_lc3_bus_arbiter;
   import lc3_bus_pkg::*;
   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
      logic       timeout;
   } vec_t;
   logic i_Clk = 1'b0;
   logic i_Rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[$];
   lc3_bus_arbiter_if #(.N_REQ(N_GATES)) bus ();
   lc3_bus_arbiter #(.N_REQ(N_GATES), .MAX_HOLD(8)) u_dut (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .bus     (bus.master)
   );
   always #5 i_Clk = ~i_Clk;

   function automatic void add(logic [3:0] r, logic [3:0] g, logic [1:0] o, logic b, logic t);
      tbl.push_back('{r, g, o, b, t});
   endfunction

   task automatic check(input string name, input logic [3:0] g, input logic [1:0] o, input logic b, input logic t);
      n_vec++;
      if ({bus.gnt, bus.owner, bus.busy, bus.timeout} !== {g, o, b, t}) begin
         n_err++;
         $display("FAIL %s: got gnt=%b owner=%0d busy=%b timeout=%b, want gnt=%b owner=%0d busy=%b timeout=%b",
                  name, bus.gnt, bus.owner, bus.busy, bus.timeout, g, o, b, t);
      end
   endtask

   task automatic step(input logic [3:0] r, input string name, input logic [3:0] g, input logic [1:0] o, input logic b, input logic t);
      bus.req = r;
      @(posedge i_Clk);
      #1;
      check(name, g, o, b, t);
   endtask

   task automatic do_reset();
      bus.req = '0;
      i_Rst_n = 1'b0;
      @(posedge i_Clk);
      #1;
      check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      i_Rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] oh;
      bus.req = '0;
      // single MDR request, release, TURN, IDLE
      add(4'b0100, 4'b0100, 2, 1, 0);
      add(4'b0000, 4'b0000, 2, 0, 0);
      add(4'b0000, 4'b0000, 2, 0, 0);
      add(4'b0000, 4'b0000, 2, 0, 0);
      // ALU beats PC; PC follows one dead cycle after ALU drops
      add(4'b1010, 4'b0010, 1, 1, 0);
      add(4'b1010, 4'b0010, 1, 1, 0);
      add(4'b1000, 4'b0000, 1, 0, 0);
      add(4'b1000, 4'b1000, 3, 1, 0);
      add(4'b0000, 4'b0000, 3, 0, 0);
      add(4'b0000, 4'b0000, 3, 0, 0);
      // lone MARMUX held past MAX_HOLD: timeout, excluded TURN, IDLE, re-grant
      for (int i = 0; i < 8; i++) add(4'b0001, 4'b0001, 0, 1, 0);
      add(4'b0001, 4'b0000, 0, 0, 1);
      add(4'b0001, 4'b0000, 0, 0, 0);
      add(4'b0001, 4'b0001, 0, 1, 0);
      add(4'b0000, 4'b0000, 0, 0, 0);
      add(4'b0000, 4'b0000, 0, 0, 0);
      // MARMUX and ALU both held: timeouts alternate ownership
      for (int i = 0; i < 8; i++) add(4'b0011, 4'b0001, 0, 1, 0);
      add(4'b0011, 4'b0000, 0, 0, 1);
      for (int i = 0; i < 8; i++) add(4'b0011, 4'b0010, 1, 1, 0);
      add(4'b0011, 4'b0000, 1, 0, 1);
      add(4'b0011, 4'b0001, 0, 1, 0);
      add(4'b0000, 4'b0000, 0, 0, 0);
      add(4'b0000, 4'b0000, 0, 0, 0);

      do_reset();
`ifndef LC3_BUS_RR_EN
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].req, $sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner, tbl[i].busy, tbl[i].timeout);
`else
      // every owner drops after two cycles and re-requests during TURN: order 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         step(4'b1111, $sformatf("rr_grant%0d", k), oh, 2'(k % 4), 1'b1, 1'b0);
         step(4'b1111, $sformatf("rr_hold%0d", k), oh, 2'(k % 4), 1'b1, 1'b0);
         step(4'b1111 & ~oh, $sformatf("rr_dead%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      end
`endif

      // reset asserted between edges drops the gate at once
      do_reset();
      step(4'b0100, "pre_rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
      #2 i_Rst_n = 1'b0;
      #1 check("async_rst_gnt", 4'b0000, 2'd0, 1'b0, 1'b0);
      bus.req = 4'b1000;
      i_Rst_n = 1'b1;
      @(posedge i_Clk);
      #1 check("post_rst_pc", 4'b1000, 2'd3, 1'b1, 1'b0);

      // reset during the timeout pulse clears it immediately
      do_reset();
      for (int i = 0; i < 8; i++) step(4'b0010, $sformatf("alu_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
      step(4'b0010, "alu_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
      #2 i_Rst_n = 1'b0;
      #1 check("async_rst_timeout", 4'b0000, 2'd0, 1'b0, 1'b0);
      i_Rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
